// File: rtl/muntjac_fetch_queue.sv
// Sequential instruction prefetcher feeding decode through a Depth-entry FIFO.
// One cache request outstanding; redirects flush the FIFO and discard stale responses.
package muntjac_fetch_pkg;

  typedef enum logic [2:0] {
    IF_PREFETCH     = 3'd0,
    IF_MISPREDICT   = 3'd1,
    IF_FENCE_I      = 3'd2,
    IF_SATP_CHANGED = 3'd3,
    IF_PROT_CHANGED = 3'd4
  } if_reason_e;

  typedef enum logic [3:0] {
    EXC_CAUSE_INSTR_ACCESS_FAULT = 4'd1,
    EXC_CAUSE_INSTR_PAGE_FAULT   = 4'd12
  } exc_cause_e;

  typedef struct packed {
    exc_cause_e  cause;
    logic [63:0] tval;
  } exception_t;

  typedef struct packed {
    logic [31:0] instr_word;
    logic [63:0] pc;
    if_reason_e  if_reason;
    logic        ex_valid;
    exception_t  exception;
  } fetched_instr_t;

endpackage

module muntjac_fetch_queue
  import muntjac_fetch_pkg::*;
#(
  parameter int unsigned     XLEN    = 64,
  parameter int unsigned     Depth   = 4,
  parameter logic [XLEN-1:0] ResetPc = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  if_reason_e      redirect_reason_i,

  output logic            req_valid_o,
  output logic [XLEN-1:0] req_pc_o,
  output if_reason_e      req_reason_o,

  input  logic            resp_valid_i,
  input  logic [31:0]     resp_instr_i,
  input  logic            resp_exception_i,
  input  logic            resp_exception_plus2_i,

  output logic            deq_valid_o,
  input  logic            deq_ready_i,
  output fetched_instr_t  deq_instr_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [XLEN-1:0] ResetPcAligned = ResetPc & ~XLEN'(1);

  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_e;

  state_e          state_q, state_d;
  logic            started_q;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  if_reason_e      pend_reason_q, pend_reason_d;
  logic            stale_q, stale_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  if_reason_e      inflight_reason_q, inflight_reason_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;

  fetched_instr_t  mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  fetched_instr_t  head_q, head_d;
  logic            head_vld_q, head_vld_d;

  logic            resp_fresh, resp_stale, enq, deq;
  logic [CntW-1:0] occ, count_after_deq;
  logic            has_room;
  logic [XLEN-1:0] npc_word, seq_pc;
  fetched_instr_t  enq_entry;
  logic            issue;
  logic [XLEN-1:0] issue_pc;
  if_reason_e      issue_reason;

  // A response racing a redirect belongs to the old stream and is discarded.
  assign resp_fresh = resp_valid_i && (state_q == WAIT) && !stale_q && !redirect_valid_i;
  assign resp_stale = resp_valid_i && (state_q == WAIT) &&  stale_q && !redirect_valid_i;
  assign enq        = resp_fresh;
  assign deq        = head_vld_q && deq_ready_i;

  // Slot reservation ignores a same-cycle dequeue so the FIFO can never overflow.
  assign occ      = count_q + CntW'(enq);
  assign has_room = occ < CntW'(Depth);

  assign npc_word = {inflight_pc_q[XLEN-1:2], 2'b00} + XLEN'(4);
  assign seq_pc   = (resp_instr_i[1:0] == 2'b11) ? inflight_pc_q + XLEN'(4)
                                                 : inflight_pc_q + XLEN'(2);

  always_comb begin
    enq_entry                 = '0;
    enq_entry.instr_word      = resp_instr_i;
    enq_entry.pc              = 64'(inflight_pc_q);
    enq_entry.if_reason       = inflight_reason_q;
    enq_entry.ex_valid        = resp_exception_i;
    enq_entry.exception.cause = EXC_CAUSE_INSTR_PAGE_FAULT;
    enq_entry.exception.tval  = resp_exception_plus2_i ? 64'(npc_word) : 64'(inflight_pc_q);
  end

  always_comb begin
    state_d           = state_q;
    pend_valid_d      = pend_valid_q;
    pend_pc_d         = pend_pc_q;
    pend_reason_d     = pend_reason_q;
    stale_d           = stale_q;
    inflight_pc_d     = inflight_pc_q;
    inflight_reason_d = inflight_reason_q;
    next_pc_d         = next_pc_q;
    issue             = 1'b0;
    issue_pc          = '0;
    issue_reason      = IF_PREFETCH;

    if (redirect_valid_i) begin
      pend_valid_d  = 1'b1;
      pend_pc_d     = redirect_pc_i & ~XLEN'(1);
      pend_reason_d = redirect_reason_i;
      if (state_q == WAIT && !resp_valid_i) begin
        stale_d = 1'b1;
      end else begin
        state_d = IDLE;
        stale_d = 1'b0;
      end
    end else if (started_q) begin
      case (state_q)
        IDLE: begin
          if (has_room) begin
            issue = 1'b1;
            if (pend_valid_q) begin
              issue_pc     = pend_pc_q;
              issue_reason = pend_reason_q;
              pend_valid_d = 1'b0;
            end else begin
              issue_pc     = next_pc_q;
              issue_reason = IF_PREFETCH;
            end
          end
        end
        WAIT: begin
          if (resp_stale) begin
            stale_d = 1'b0;
            if (pend_valid_q) begin
              issue        = 1'b1;
              issue_pc     = pend_pc_q;
              issue_reason = pend_reason_q;
              pend_valid_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else if (resp_fresh) begin
            next_pc_d = seq_pc;
            if (resp_exception_i) begin
              state_d = HALT;
            end else if (has_room) begin
              issue        = 1'b1;
              issue_pc     = seq_pc;
              issue_reason = IF_PREFETCH;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: ;
      endcase
    end

    if (issue) begin
      state_d           = WAIT;
      inflight_pc_d     = issue_pc;
      inflight_reason_d = issue_reason;
    end
  end

  assign req_valid_o  = issue;
  assign req_pc_o     = issue_pc;
  assign req_reason_o = issue_reason;

  always_comb begin
    count_after_deq = count_q - CntW'(deq);
    if (redirect_valid_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(enq);
      rd_ptr_d = rd_ptr_q + PtrW'(deq);
      count_d  = count_after_deq + CntW'(enq);
    end
    // The head register bypasses the array when the new entry lands straight at the head.
    head_vld_d = (count_d != '0);
    if (!head_vld_d) begin
      head_d = '0;
    end else if (enq && count_after_deq == '0) begin
      head_d = enq_entry;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  assign deq_valid_o = head_vld_q;
  assign deq_instr_o = head_q;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= enq_entry;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      started_q         <= 1'b0;
      pend_valid_q      <= 1'b1;
      pend_pc_q         <= ResetPcAligned;
      pend_reason_q     <= IF_FENCE_I;
      stale_q           <= 1'b0;
      inflight_pc_q     <= '0;
      inflight_reason_q <= IF_PREFETCH;
      next_pc_q         <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      head_q            <= '0;
      head_vld_q        <= 1'b0;
    end else begin
      state_q           <= state_d;
      started_q         <= 1'b1;
      pend_valid_q      <= pend_valid_d;
      pend_pc_q         <= pend_pc_d;
      pend_reason_q     <= pend_reason_d;
      stale_q           <= stale_d;
      inflight_pc_q     <= inflight_pc_d;
      inflight_reason_q <= inflight_reason_d;
      next_pc_q         <= next_pc_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      head_q            <= head_d;
      head_vld_q        <= head_vld_d;
    end
  end

  // Stale responses are only ever owed while still in WAIT.
  resp_only_when_waiting: assert property (@(posedge clk_i) disable iff (!rst_ni)
    resp_valid_i |-> state_q == WAIT);

  count_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CntW'(Depth));

endmodule

// File: tb/tb_muntjac_fetch_queue.sv
// Directed bench for muntjac_fetch_queue: cache responses are driven by hand and the
// expected decode entries are queued when each response is driven.
module tb_muntjac_fetch_queue;
  import muntjac_fetch_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           redirect_valid_i = 1'b0;
  logic [63:0]    redirect_pc_i = '0;
  if_reason_e     redirect_reason_i = IF_PREFETCH;
  logic           req_valid_o;
  logic [63:0]    req_pc_o;
  if_reason_e     req_reason_o;
  logic           resp_valid_i = 1'b0;
  logic [31:0]    resp_instr_i = '0;
  logic           resp_exception_i = 1'b0;
  logic           resp_exception_plus2_i = 1'b0;
  logic           deq_valid_o;
  logic           deq_ready_i = 1'b0;
  fetched_instr_t deq_instr_o;

  int checks = 0;
  int errors = 0;
  fetched_instr_t sb[$];
  logic [63:0] cur_pc = '0;
  if_reason_e  cur_rsn = IF_PREFETCH;

  muntjac_fetch_queue #(.XLEN(64), .Depth(4), .ResetPc(64'h1000)) dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .redirect_valid_i       (redirect_valid_i),
    .redirect_pc_i          (redirect_pc_i),
    .redirect_reason_i      (redirect_reason_i),
    .req_valid_o            (req_valid_o),
    .req_pc_o               (req_pc_o),
    .req_reason_o           (req_reason_o),
    .resp_valid_i           (resp_valid_i),
    .resp_instr_i           (resp_instr_i),
    .resp_exception_i       (resp_exception_i),
    .resp_exception_plus2_i (resp_exception_plus2_i),
    .deq_valid_o            (deq_valid_o),
    .deq_ready_i            (deq_ready_i),
    .deq_instr_o            (deq_instr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Every accepted head entry must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni && deq_valid_o && deq_ready_i) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL deq_unexpected: observed pc %0h expected no entry", deq_instr_o.pc);
      end
      if (sb.size() != 0) begin
        fetched_instr_t e;
        e = sb.pop_front();
        chk("deq_entry", 256'(deq_instr_o), 256'(e));
      end
    end
  end

  task automatic wait_req(input logic [63:0] pc, input if_reason_e r, input int max,
                          input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk_i);
      if (req_valid_o) found = 1'b1;
      else next_cycle();
    end
    checks++;
    assert (found === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout: observed no request expected pc %0h", tag, pc);
    end
    if (found) begin
      chk({tag, "_pc"}, 256'(req_pc_o), 256'(pc));
      chk({tag, "_rsn"}, 256'(req_reason_o), 256'(r));
      cur_pc  = pc;
      cur_rsn = r;
      next_cycle();
    end
  endtask

  task automatic resp(input logic [31:0] ins, input logic ex, input logic p2, input logic stale,
                      input logic exp_req, input logic [63:0] exp_pc, input if_reason_e exp_rsn,
                      input string tag);
    fetched_instr_t e;
    resp_valid_i           = 1'b1;
    resp_instr_i           = ins;
    resp_exception_i       = ex;
    resp_exception_plus2_i = p2;
    @(negedge clk_i);
    if (!stale) begin
      e = '0;
      e.instr_word      = ins;
      e.pc              = cur_pc;
      e.if_reason       = cur_rsn;
      e.ex_valid        = ex;
      e.exception.cause = EXC_CAUSE_INSTR_PAGE_FAULT;
      e.exception.tval  = p2 ? ({cur_pc[63:2], 2'b00} + 64'd4) : cur_pc;
      sb.push_back(e);
    end
    chk({tag, "_req_vld"}, 256'(req_valid_o), 256'(exp_req));
    if (exp_req) begin
      chk({tag, "_req_pc"}, 256'(req_pc_o), 256'(exp_pc));
      chk({tag, "_req_rsn"}, 256'(req_reason_o), 256'(exp_rsn));
      cur_pc  = exp_pc;
      cur_rsn = exp_rsn;
    end
    next_cycle();
    resp_valid_i           = 1'b0;
    resp_exception_i       = 1'b0;
    resp_exception_plus2_i = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] pc, input if_reason_e r, input logic with_resp,
                          input string tag);
    redirect_valid_i  = 1'b1;
    redirect_pc_i     = pc;
    redirect_reason_i = r;
    resp_valid_i      = with_resp;
    resp_instr_i      = 32'h0000_0013;
    @(negedge clk_i);
    chk({tag, "_no_req"}, 256'(req_valid_o), 256'(0));
    next_cycle();
    redirect_valid_i = 1'b0;
    resp_valid_i     = 1'b0;
    sb.delete();
  endtask

  initial begin
    // Reset and first fetch from ResetPc.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_deq_vld", 256'(deq_valid_o), 256'(0));
    chk("rst_req_vld", 256'(req_valid_o), 256'(0));
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("first_cycle_no_req", 256'(req_valid_o), 256'(0));
    next_cycle();
    wait_req(64'h1000, IF_FENCE_I, 1, "boot");
    deq_ready_i = 1'b1;
    resp(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1004, IF_PREFETCH, "boot_resp");
    @(negedge clk_i);
    chk("boot_deq_vld", 256'(deq_valid_o), 256'(1));
    chk("boot_deq_pc", 256'(deq_instr_o.pc), 256'(64'h1000));
    next_cycle();

    // Redirect into a compressed stream while a request is outstanding.
    redirect(64'h2002, IF_MISPREDICT, 1'b0, "redir_2002");
    resp(32'hdead_beef, 1'b0, 1'b0, 1'b1, 1'b1, 64'h2002, IF_MISPREDICT, "stale_1004");
    resp(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2004, IF_PREFETCH, "c_2002");
    resp(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2006, IF_PREFETCH, "c_2004");
    resp(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2008, IF_PREFETCH, "c_2006");
    next_cycle();

    // Fill the FIFO with decode stalled.
    deq_ready_i = 1'b0;
    resp(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 64'h200c, IF_PREFETCH, "fill1");
    resp(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2010, IF_PREFETCH, "fill2");
    resp(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2014, IF_PREFETCH, "fill3");
    resp(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, IF_PREFETCH, "fill4_full");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("full_no_req", 256'(req_valid_o), 256'(0));
      chk("full_deq_vld", 256'(deq_valid_o), 256'(1));
      next_cycle();
    end
    deq_ready_i = 1'b1;
    @(negedge clk_i);
    chk("one_deq_no_req_yet", 256'(req_valid_o), 256'(0));
    next_cycle();
    deq_ready_i = 1'b0;
    wait_req(64'h2018, IF_PREFETCH, 1, "refill");
    @(negedge clk_i);
    chk("refill_single", 256'(req_valid_o), 256'(0));
    next_cycle();

    // Redirect with three entries queued and one request in flight.
    redirect(64'h8000, IF_SATP_CHANGED, 1'b0, "redir_8000");
    @(negedge clk_i);
    chk("flush_deq_vld", 256'(deq_valid_o), 256'(0));
    next_cycle();
    deq_ready_i = 1'b1;
    resp(32'h1234_5677, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000, IF_SATP_CHANGED, "stale_2018");
    resp(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8004, IF_PREFETCH, "r_8000");

    // Response colliding with a redirect is dropped; then a page fault halts fetch.
    redirect(64'h3ffe, IF_PROT_CHANGED, 1'b1, "redir_3ffe");
    wait_req(64'h3ffe, IF_PROT_CHANGED, 2, "pf_req");
    resp(32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, IF_PREFETCH, "pf_resp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk("halt_no_req", 256'(req_valid_o), 256'(0));
      next_cycle();
    end

    // Address wrap at the top of the 64-bit space.
    redirect(64'hffff_ffff_ffff_fffc, IF_MISPREDICT, 1'b0, "redir_wrap");
    wait_req(64'hffff_ffff_ffff_fffc, IF_MISPREDICT, 2, "wrap_req");
    resp(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0, IF_PREFETCH, "wrap_resp");
    resp(32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b1, 64'h4, IF_PREFETCH, "after_wrap");
    repeat (2) next_cycle();
    @(negedge clk_i);
    chk("drained_deq_vld", 256'(deq_valid_o), 256'(0));
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
